// File: rtl/systolic_skew_feeder_if.sv
// Producer- and array-side signal bundle for the systolic skew feeder.
interface systolic_skew_feeder_if #(
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned DEPTH     = 4
);
  localparam int unsigned LANE_W = BIT_WIDTH * DEPTH;

  logic              start;
  logic [LANE_W-1:0] wt_col_in;
  logic              wt_col_valid;
  logic              wt_col_ready;
  logic [LANE_W-1:0] vec_in;
  logic              vec_valid;
  logic              vec_last;
  logic              vec_ready;
  logic              control;
  logic [LANE_W-1:0] wt_arr;
  logic [LANE_W-1:0] data_arr;
  logic              busy;
  logic              done;
  logic [15:0]       vec_count;

  modport master (
    output start, wt_col_in, wt_col_valid, vec_in, vec_valid, vec_last,
    input  wt_col_ready, vec_ready, control, wt_arr, data_arr, busy, done, vec_count
  );

  modport slave (
    input  start, wt_col_in, wt_col_valid, vec_in, vec_valid, vec_last,
    output wt_col_ready, vec_ready, control, wt_arr, data_arr, busy, done, vec_count
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Loads weight columns into a DEPTH x DEPTH weight-stationary array, then re-times
// row-parallel data vectors into the diagonal pattern the array consumes.
module systolic_skew_feeder #(
  parameter int unsigned BIT_WIDTH    = 16,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned FLUSH_CYCLES = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  systolic_skew_feeder_if.slave bus
);
  localparam int unsigned LANE_W    = BIT_WIDTH * DEPTH;
  localparam int unsigned DRAIN_LEN = DEPTH - 1 + FLUSH_CYCLES;
  localparam int unsigned CNT_W     = $clog2(DRAIN_LEN + DEPTH + 1);
  localparam int unsigned VCNT_W    = 16;

  typedef enum logic [2:0] {IDLE, LOAD_W, SETTLE, STREAM, DRAIN, DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [VCNT_W-1:0]   vec_count_q, vec_count_d;
  logic                control_q, control_d;
  logic [LANE_W-1:0]   wt_arr_q, wt_arr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                wt_ready_q, wt_ready_d;
  logic                vec_ready_q, vec_ready_d;
  logic                wt_acc, vec_acc;
  logic [LANE_W-1:0]   data_arr_w;

  assign wt_acc  = bus.wt_col_valid & wt_ready_q;
  assign vec_acc = bus.vec_valid & vec_ready_q;

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      vec_count_q <= '0;
      control_q   <= 1'b0;
      wt_arr_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wt_ready_q  <= 1'b0;
      vec_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vec_count_q <= vec_count_d;
      control_q   <= control_d;
      wt_arr_q    <= wt_arr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wt_ready_q  <= wt_ready_d;
      vec_ready_q <= vec_ready_d;
    end
  end

  // Next state; cnt_q counts accepted columns in LOAD_W and remaining cycles in DRAIN
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vec_count_d = vec_count_q;
    control_d   = 1'b0;
    wt_arr_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = LOAD_W;
          cnt_d       = '0;
          vec_count_d = '0;
        end
      end
      LOAD_W: begin
        if (wt_acc) begin
          control_d = 1'b1;
          wt_arr_d  = bus.wt_col_in;
          if (cnt_q == CNT_W'(DEPTH - 1)) begin
            state_d = SETTLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      SETTLE: state_d = STREAM;
      STREAM: begin
        if (vec_acc) begin
          if (vec_count_q != '1) vec_count_d = vec_count_q + VCNT_W'(1);
          if (bus.vec_last) begin
            state_d = DRAIN;
            cnt_d   = CNT_W'(DRAIN_LEN - 1);
          end
        end
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      DONE: begin
        state_d     = IDLE;
        vec_count_d = '0;
      end
      default: state_d = IDLE;
    endcase
    busy_d      = (state_d == LOAD_W) || (state_d == SETTLE) ||
                  (state_d == STREAM) || (state_d == DRAIN);
    done_d      = (state_d == DONE);
    wt_ready_d  = (state_d == LOAD_W);
    vec_ready_d = (state_d == STREAM);
  end

  // Lane i is an (i+1)-deep shift register; idle slots shift in zeros
  for (genvar i = 0; i < DEPTH; i++) begin : g_lane
    localparam int unsigned PIPE_W = (i + 1) * BIT_WIDTH;
    logic [PIPE_W-1:0]    pipe_q;
    logic [BIT_WIDTH-1:0] lane_d;

    assign lane_d = vec_acc ? bus.vec_in[i*BIT_WIDTH +: BIT_WIDTH] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pipe_q <= '0;
      else        pipe_q <= PIPE_W'({pipe_q, lane_d});
    end

    assign data_arr_w[i*BIT_WIDTH +: BIT_WIDTH] = pipe_q[PIPE_W-1 -: BIT_WIDTH];
  end

  assign bus.wt_col_ready = wt_ready_q;
  assign bus.vec_ready    = vec_ready_q;
  assign bus.control      = control_q;
  assign bus.wt_arr       = wt_arr_q;
  assign bus.data_arr     = data_arr_w;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.vec_count    = vec_count_q;
endmodule
